// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg
//   Shared types and constants for the SPI command decoder.
//   state_t    : decoder FSM states
//   RW_BIT     : command-byte bit selecting read (1) or write (0)
//   STATUS_SIG : fixed upper nibble of the status byte (SPI_CMD_STATUS_EN builds)
//   CMD_READ / CMD_WRITE : values of the RW bit
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_WR     = 3'd2,
    S_RD     = 3'd3,
    S_RD_CAP = 3'd4
  } state_t;

  localparam int         RW_BIT     = 7;
  localparam logic [3:0] STATUS_SIG = 4'hA;
  localparam logic       CMD_READ   = 1'b1;
  localparam logic       CMD_WRITE  = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for signals crossing into i_Clk. The reset value
//   is a parameter so inactive-high lines (e.g. a chip-select) come out of
//   reset in their deasserted state.
// Ports:
//   i_Clk   : destination clock
//   i_Rst_L : asynchronous reset, active low (flops load RST_VAL)
//   i_D     : asynchronous input
//   o_Q     : synchronised output
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic [WIDTH-1:0] i_D,
  output logic [WIDTH-1:0] o_Q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_D;
      r_sync <= r_meta;
    end
  end

  assign o_Q = r_sync;

endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
//   Turns received SPI bytes into register-bus operations. The first byte of
//   a transaction is a command: bit 7 selects read/write, the low ADDR_W bits
//   give the start address. Writes take every following byte as data; reads
//   return data as TX bytes, with each following (dummy) byte fetching the
//   next address. The address auto-increments and wraps silently.
//   Transaction boundaries come from a synchronised copy of i_SPI_CS_n; the
//   transaction closes once CS has been high for CS_HOLD cycles.
//
// Optional build macro: SPI_CMD_STATUS_EN
//   When defined, a status byte {4'hA, wrap_seen, last_was_write,
//   last_was_read, 1} is loaded into the TX path on every return to idle and
//   once after reset release, so the master shifts it out while sending the
//   next command byte.
//
// Ports:
//   i_Clk, i_Rst_L       : system clock, async active-low reset
//   i_RX_DV, i_RX_Byte   : received-byte pulse and data from the SPI slave
//   o_TX_DV, o_TX_Byte   : TX load pulse and byte to the SPI slave
//   i_SPI_CS_n           : raw chip-select (asynchronous, active low)
//   o_Reg_Addr           : register bus address
//   o_Reg_Wr_En/Wr_Data  : one-cycle write strobe and data
//   o_Reg_Rd_En          : one-cycle read strobe; i_Reg_Rd_Data valid 1 cycle later
//   i_Reg_Rd_Data        : register read data
//   o_Busy               : high while a transaction is open
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | no transaction; waiting for synced CS to go low
// S_CMD    | CS low, waiting for the command byte
// S_WR     | write burst: each RX byte becomes a write strobe
// S_RD     | read burst: each RX (dummy) byte fetches the next address
// S_RD_CAP | read strobe in flight; capture data into the TX path
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int CS_HOLD = 4
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  input  logic              i_SPI_CS_n,
  output logic [ADDR_W-1:0] o_Reg_Addr,
  output logic              o_Reg_Wr_En,
  output logic [7:0]        o_Reg_Wr_Data,
  output logic              o_Reg_Rd_En,
  input  logic [7:0]        i_Reg_Rd_Data,
  output logic              o_Busy
);

  localparam int               HOLD_W    = 4;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HOLD - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_tx_dv;
  logic [7:0]        r_tx_byte;
  logic              r_wr_en;
  logic [7:0]        r_wr_data;
  logic              r_rd_en;

  logic w_cs_s;
  logic w_cs_end;
  logic w_addr_inc;
  logic w_go_idle;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_D     (i_SPI_CS_n),
    .o_Q     (w_cs_s)
  );

  // r_hold_cnt counts prior consecutive high samples, so the current sample
  // makes CS_HOLD in a row when it reaches HOLD_LAST.
  assign w_cs_end = w_cs_s && (r_hold_cnt == HOLD_LAST) && (r_state != S_IDLE);

  // Address steps after each write strobe and after each read capture.
  assign w_addr_inc = r_wr_en || ((r_state == S_RD_CAP) && !r_rd_en);

  // Close only when nothing is in flight: a late RX byte or an outstanding
  // write strobe keeps the transaction open one more cycle. S_RD_CAP is
  // excluded so a started read always finishes its capture.
  assign w_go_idle = w_cs_end && !i_RX_DV && !r_wr_en &&
                     (r_state inside {S_CMD, S_WR, S_RD});

`ifdef SPI_CMD_STATUS_EN
  logic       r_status_pend;
  logic       r_wrap_seen;
  logic       r_last_wr;
  logic       r_last_rd;
  logic [7:0] w_status;

  assign w_status = {STATUS_SIG, r_wrap_seen, r_last_wr, r_last_rd, 1'b1};
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_hold_cnt <= '0;
      r_tx_dv    <= 1'b0;
      r_tx_byte  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_rd_en    <= 1'b0;
`ifdef SPI_CMD_STATUS_EN
      r_status_pend <= 1'b1;
      r_wrap_seen   <= 1'b0;
      r_last_wr     <= 1'b0;
      r_last_rd     <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_tx_dv <= 1'b0;

      if (!w_cs_s || (r_state == S_IDLE)) begin
        r_hold_cnt <= '0;
      end else if (r_hold_cnt != HOLD_LAST) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end

      if (w_addr_inc) begin
        r_addr <= r_addr + ADDR_W'(1);
      end

`ifdef SPI_CMD_STATUS_EN
      if (w_addr_inc && (&r_addr)) begin
        r_wrap_seen <= 1'b1;
      end
      if (r_wr_en) begin
        r_last_wr <= 1'b1;
      end
      if (r_rd_en) begin
        r_last_rd <= 1'b1;
      end
      if (r_status_pend || w_go_idle) begin
        r_status_pend <= 1'b0;
        r_tx_dv       <= 1'b1;
        r_tx_byte     <= w_status;
      end
`endif

      case (r_state)
        S_IDLE: begin
          if (!w_cs_s) begin
            r_state <= S_CMD;
`ifdef SPI_CMD_STATUS_EN
            r_wrap_seen <= 1'b0;
            r_last_wr   <= 1'b0;
            r_last_rd   <= 1'b0;
`endif
          end
        end

        S_CMD: begin
          if (i_RX_DV) begin
            r_addr <= i_RX_Byte[ADDR_W-1:0];
            case (i_RX_Byte[RW_BIT])
              CMD_READ: begin
                r_rd_en <= 1'b1;
                r_state <= S_RD_CAP;
              end
              CMD_WRITE: r_state <= S_WR;
              default:   r_state <= S_WR;
            endcase
          end else if (w_go_idle) begin
            r_state <= S_IDLE;
          end
        end

        S_WR: begin
          if (i_RX_DV) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= i_RX_Byte;
          end else if (w_go_idle) begin
            r_state <= S_IDLE;
          end
        end

        S_RD: begin
          if (i_RX_DV) begin
            r_rd_en <= 1'b1;
            r_state <= S_RD_CAP;
          end else if (w_go_idle) begin
            r_state <= S_IDLE;
          end
        end

        S_RD_CAP: begin
          // First cycle here is the strobe itself; data arrives the cycle after.
          if (!r_rd_en) begin
            r_tx_byte <= i_Reg_Rd_Data;
            r_tx_dv   <= 1'b1;
            r_state   <= S_RD;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_TX_DV       = r_tx_dv;
  assign o_TX_Byte     = r_tx_byte;
  assign o_Reg_Addr    = r_addr;
  assign o_Reg_Wr_En   = r_wr_en;
  assign o_Reg_Wr_Data = r_wr_data;
  assign o_Reg_Rd_En   = r_rd_en;
  assign o_Busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder
//   Directed bench for spi_cmd_decoder: a table of burst transactions with
//   hand-computed strobes/TX bytes, plus sequences for late RX, aborts,
//   idle RX and reset in the middle of a burst. Status-byte expectations
//   apply when SPI_CMD_STATUS_EN is defined.
module tb_spi_cmd_decoder;

  localparam int ADDR_W  = 7;
  localparam int CS_HOLD = 4;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              rx_dv   = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              cs_n    = 1'b1;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              rd_en;
  logic [7:0]        rd_data = 8'h00;
  logic              busy;

  spi_cmd_decoder #(
    .ADDR_W  (ADDR_W),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_RX_DV       (rx_dv),
    .i_RX_Byte     (rx_byte),
    .o_TX_DV       (tx_dv),
    .o_TX_Byte     (tx_byte),
    .i_SPI_CS_n    (cs_n),
    .o_Reg_Addr    (addr),
    .o_Reg_Wr_En   (wr_en),
    .o_Reg_Wr_Data (wr_data),
    .o_Reg_Rd_En   (rd_en),
    .i_Reg_Rd_Data (rd_data),
    .o_Busy        (busy)
  );

  always #5 clk = ~clk;

  // Register file peripheral: registered read, data valid the cycle after rd_en.
  logic [7:0] regs [128];
  logic       load_init = 1'b0;

  always @(posedge clk) begin
    if (load_init) begin
      regs[16] <= 8'hAB;
      regs[17] <= 8'hCD;
    end else if (wr_en) begin
      regs[addr] <= wr_data;
    end
    if (rd_en) rd_data <= regs[addr];
  end

  // Event monitor, sampled on the falling edge.
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         lat;
  } ev_t;

  ev_t        wr_q[$];
  ev_t        rd_q[$];
  ev_t        tx_q[$];
  logic [7:0] st_q[$];
  int         cyc     = 0;
  int         last_rx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_dv) last_rx = cyc;
    if (wr_en) wr_q.push_back('{{1'b0, addr}, wr_data, cyc - last_rx});
    if (rd_en) rd_q.push_back('{{1'b0, addr}, 8'h00, cyc - last_rx});
    if (tx_dv) begin
      if (busy) tx_q.push_back('{8'h00, tx_byte, cyc - last_rx});
      else      st_q.push_back(tx_byte);
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_q();
    wr_q.delete();
    rd_q.delete();
    tx_q.delete();
    st_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_dv   = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  task automatic cs_start();
    int n = 0;
    @(posedge clk); #1;
    cs_n = 1'b0;
    while (!busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cs_start_busy", busy, 1);
  endtask

  // Raise CS and require o_Busy to drop exactly CS_HOLD+2 edges later.
  task automatic cs_end_check(input string nm);
    int n = 0;
    @(posedge clk); #1;
    cs_n = 1'b1;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, n, CS_HOLD + 2);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, busy, 0);
  endtask

  task automatic chk_status(input string nm, input logic [7:0] exp);
`ifdef SPI_CMD_STATUS_EN
    chk({nm, "_status_count"}, st_q.size(), 1);
    if (st_q.size() > 0) chk({nm, "_status_byte"}, st_q[0], exp);
`else
    chk({nm, "_status_count"}, st_q.size(), 0);
    if (st_q.size() > 0) chk({nm, "_status_byte"}, st_q[0], 8'h00);
`endif
  endtask

  typedef struct {
    logic       rd;
    logic [7:0] cmd;
    int         n;
    logic [7:0] d  [3];
    logic [7:0] ea [4];
    logic [7:0] ed [4];
    logic [7:0] st;
  } vec_t;

  vec_t vecs [6];

  // Byte lists are written left to right: d0_d1_d2, ea0_ea1_ea2_ea3.
  function automatic vec_t mk(input logic rd, input logic [7:0] cmd, input int n,
                              input logic [23:0] d, input logic [31:0] ea,
                              input logic [31:0] ed, input logic [7:0] st);
    vec_t v;
    v.rd  = rd;
    v.cmd = cmd;
    v.n   = n;
    for (int i = 0; i < 3; i++) v.d[i] = d[8*(2-i) +: 8];
    for (int i = 0; i < 4; i++) begin
      v.ea[i] = ea[8*(3-i) +: 8];
      v.ed[i] = ed[8*(3-i) +: 8];
    end
    v.st = st;
    return v;
  endfunction

  task automatic run_vec(input int k);
    int    nexp;
    string p;
    p = $sformatf("v%0d", k);
    clear_q();
    cs_start();
    send_byte(vecs[k].cmd);
    for (int i = 0; i < vecs[k].n; i++) send_byte(vecs[k].d[i]);
    cs_end_check({p, "_busy_fall"});
    repeat (2) @(posedge clk);
    #1;
    nexp = vecs[k].rd ? vecs[k].n + 1 : vecs[k].n;
    if (vecs[k].rd) begin
      chk({p, "_rd_count"}, rd_q.size(), nexp);
      chk({p, "_tx_count"}, tx_q.size(), nexp);
      chk({p, "_wr_count"}, wr_q.size(), 0);
      for (int j = 0; j < nexp; j++) begin
        if (j < rd_q.size()) chk($sformatf("%s_rd_addr%0d", p, j), rd_q[j].a, vecs[k].ea[j]);
        if (j < tx_q.size()) begin
          chk($sformatf("%s_tx_byte%0d", p, j), tx_q[j].d, vecs[k].ed[j]);
          chk($sformatf("%s_tx_lat%0d", p, j), tx_q[j].lat, 3);
        end
      end
    end else begin
      chk({p, "_wr_count"}, wr_q.size(), nexp);
      chk({p, "_rd_count"}, rd_q.size(), 0);
      chk({p, "_tx_count"}, tx_q.size(), 0);
      for (int j = 0; j < nexp; j++) begin
        if (j < wr_q.size()) begin
          chk($sformatf("%s_wr_addr%0d", p, j), wr_q[j].a, vecs[k].ea[j]);
          chk($sformatf("%s_wr_data%0d", p, j), wr_q[j].d, vecs[k].ed[j]);
          chk($sformatf("%s_wr_lat%0d", p, j), wr_q[j].lat, 1);
        end
      end
    end
    chk_status(p, vecs[k].st);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(1'b0, 8'h05, 3, 24'h11_22_33, 32'h05_06_07_00, 32'h11_22_33_00, 8'hA5);
    vecs[1] = mk(1'b1, 8'h90, 1, 24'h00_00_00, 32'h10_11_00_00, 32'hAB_CD_00_00, 8'hA3);
    vecs[2] = mk(1'b0, 8'h7F, 2, 24'h5A_A5_00, 32'h7F_00_00_00, 32'h5A_A5_00_00, 8'hAD);
    vecs[3] = mk(1'b1, 8'h85, 2, 24'hFF_00_00, 32'h05_06_07_00, 32'h11_22_33_00, 8'hA3);
    vecs[4] = mk(1'b1, 8'hFF, 1, 24'h00_00_00, 32'h7F_00_00_00, 32'h5A_A5_00_00, 8'hAB);
    vecs[5] = mk(1'b0, 8'h20, 1, 24'hC3_00_00, 32'h20_00_00_00, 32'hC3_00_00_00, 8'hA5);

    // Reset state
    load_init = 1'b1;
    @(posedge clk); #1;
    load_init = 1'b0;
    chk("rst_busy",  busy,    0);
    chk("rst_wr_en", wr_en,   0);
    chk("rst_rd_en", rd_en,   0);
    chk("rst_tx_dv", tx_dv,   0);
    chk("rst_tx",    tx_byte, 0);
    chk("rst_addr",  addr,    0);
    chk("rst_wdata", wr_data, 0);
    clear_q();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk_status("post_rst", 8'hA1);

    // RX while CS is high is ignored
    clear_q();
    send_byte(8'h85);
    chk("idle_rx_busy",  busy, 0);
    chk("idle_rx_rd",    rd_q.size(), 0);
    chk("idle_rx_wr",    wr_q.size(), 0);
    chk("idle_rx_tx",    tx_q.size() + st_q.size(), 0);

    // Table of bursts
    for (int k = 0; k < 6; k++) run_vec(k);

    // Last RX arrives two cycles after synced CS rises
    clear_q();
    cs_start();
    send_byte(8'h30);
    send_byte(8'h44);
    @(posedge clk); #1;
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rx_dv   = 1'b1;
    rx_byte = 8'h55;
    @(posedge clk); #1;
    rx_dv = 1'b0;
    chk("late_busy_at_rx", busy, 1);
    wait_idle("late_idle");
    repeat (2) @(posedge clk);
    #1;
    chk("late_wr_count", wr_q.size(), 2);
    if (wr_q.size() > 1) begin
      chk("late_wr_addr", wr_q[1].a, 8'h31);
      chk("late_wr_data", wr_q[1].d, 8'h55);
    end
    chk_status("late", 8'hA5);

    // CS pulse with no bytes at all
    clear_q();
    cs_start();
    repeat (6) @(posedge clk);
    cs_end_check("abort0_busy_fall");
    repeat (2) @(posedge clk);
    #1;
    chk("abort0_events", wr_q.size() + rd_q.size() + tx_q.size(), 0);
    chk_status("abort0", 8'hA1);

    // Write command only, then CS high
    clear_q();
    cs_start();
    send_byte(8'h12);
    cs_end_check("abort1_busy_fall");
    repeat (2) @(posedge clk);
    #1;
    chk("abort1_events", wr_q.size() + rd_q.size() + tx_q.size(), 0);
    chk_status("abort1", 8'hA1);

    // Reset asserted while a write strobe is on the bus
    clear_q();
    cs_start();
    send_byte(8'h40);
    send_byte(8'h01);
    @(posedge clk); #1;
    rx_dv   = 1'b1;
    rx_byte = 8'h02;
    @(posedge clk); #1;
    rx_dv = 1'b0;
    chk("midrst_strobe_up", wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", wr_en,   0);
    chk("midrst_busy",  busy,    0);
    chk("midrst_addr",  addr,    0);
    chk("midrst_tx",    tx_byte, 0);
    chk("midrst_rd_en", rd_en,   0);
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_wr_count", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("midrst_wr_addr", wr_q[0].a, 8'h40);
    chk("midrst_idle", busy, 0);
    chk_status("midrst", 8'hA1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
